// File: rtl/xram_pkg.sv
// Shared definitions for the XRAM front end: command encodings, MMIO window
// defaults and the read-return tag.
package xram_pkg;

  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;

  localparam logic [15:0] AES_BASE_DEF = 16'hFE00;
  localparam logic [15:0] SHA_BASE_DEF = 16'hFE80;
  localparam int          WIN_BITS     = 7;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_CPU_MEM,
    TAG_CPU_AES,
    TAG_CPU_SHA,
    TAG_M0,
    TAG_M1
  } tag_t;

  function automatic logic win_hit(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:WIN_BITS] == base[15:WIN_BITS];
  endfunction

endpackage

// File: rtl/xram_arb_rr_arb2.sv
// Two-requester round-robin arbiter; combinational one-hot grant, zero when disabled.
// last_grant moves only when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_grant ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/xram_arb.sv
// XRAM front end: decodes CPU accesses into MMIO or SRAM, arbitrates DMA for
// leftover SRAM cycles and routes one-cycle-late read data back to its source.
module xram_arb
  import xram_pkg::*;
#(
  parameter logic [15:0] AES_BASE = AES_BASE_DEF,
  parameter logic [15:0] SHA_BASE = SHA_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cpu_cmd,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic [1:0]  aes_cmd,
  output logic [1:0]  sha_cmd,
  output logic [15:0] mmio_addr,
  output logic [7:0]  mmio_wdata,
  input  logic [7:0]  aes_rdata,
  input  logic [7:0]  sha_rdata,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic        m0_rvalid,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic        m1_rvalid,
  output logic [7:0]  m1_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  logic       cpu_act, cpu_rd, aes_hit, sha_hit, cpu_mem;
  logic [1:0] gnt;
  tag_t       cpu_tag, cpu_tag_d, dma_tag, dma_tag_d;
  logic [7:0] mmio_rdata_q, mmio_rdata_d;

  assign cpu_act = (cpu_cmd == CMD_RD) || (cpu_cmd == CMD_WR);
  assign cpu_rd  = (cpu_cmd == CMD_RD);
  assign aes_hit = cpu_act && win_hit(cpu_addr, AES_BASE);
  assign sha_hit = cpu_act && win_hit(cpu_addr, SHA_BASE);
  assign cpu_mem = cpu_act && !aes_hit && !sha_hit;

  assign aes_cmd    = aes_hit ? cpu_cmd : CMD_IDLE;
  assign sha_cmd    = sha_hit ? cpu_cmd : CMD_IDLE;
  assign mmio_addr  = cpu_addr;
  assign mmio_wdata = cpu_wdata;

  // The CPU cannot stall, so its SRAM access disables DMA arbitration outright.
  rr_arb2 u_rr (
    .clk (clk),
    .rst (rst),
    .en  (!cpu_mem),
    .req ({m1_req, m0_req}),
    .gnt (gnt)
  );

  assign m0_ack = gnt[0];
  assign m1_ack = gnt[1];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    if (cpu_mem) begin
      mem_en    = 1'b1;
      mem_we    = (cpu_cmd == CMD_WR);
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = m0_wr;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = m1_wr;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // CPU and DMA can both have a read in flight when the CPU is on MMIO.
  always_comb begin
    cpu_tag_d    = TAG_NONE;
    mmio_rdata_d = 8'h00;
    if (cpu_rd) begin
      if (aes_hit) begin
        cpu_tag_d    = TAG_CPU_AES;
        mmio_rdata_d = aes_rdata;
      end else if (sha_hit) begin
        cpu_tag_d    = TAG_CPU_SHA;
        mmio_rdata_d = sha_rdata;
      end else begin
        cpu_tag_d = TAG_CPU_MEM;
      end
    end
  end

  always_comb begin
    dma_tag_d = TAG_NONE;
    if (gnt[0] && !m0_wr) begin
      dma_tag_d = TAG_M0;
    end else if (gnt[1] && !m1_wr) begin
      dma_tag_d = TAG_M1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_tag      <= TAG_NONE;
      dma_tag      <= TAG_NONE;
      mmio_rdata_q <= 8'h00;
    end else begin
      cpu_tag      <= cpu_tag_d;
      dma_tag      <= dma_tag_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  always_comb begin
    cpu_rvalid = 1'b0;
    cpu_rdata  = 8'h00;
    case (cpu_tag)
      TAG_CPU_MEM: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = mem_rdata;
      end
      TAG_CPU_AES, TAG_CPU_SHA: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = mmio_rdata_q;
      end
      default: ;
    endcase
  end

  assign m0_rvalid = (dma_tag == TAG_M0);
  assign m1_rvalid = (dma_tag == TAG_M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : 8'h00;
  assign m1_rdata  = m1_rvalid ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_xram_arb.sv
// Directed, table-driven bench for xram_arb with a behavioural SRAM model.
module tb_xram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cpu_cmd;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_rvalid;
  logic [1:0]  aes_cmd, sha_cmd;
  logic [15:0] mmio_addr;
  logic [7:0]  mmio_wdata, aes_rdata, sha_rdata;
  logic        m0_req, m0_wr, m0_ack, m0_rvalid;
  logic [15:0] m0_addr;
  logic [7:0]  m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_ack, m1_rvalid;
  logic [15:0] m1_addr;
  logic [7:0]  m1_wdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  logic [7:0]  sram [0:65535];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  xram_arb dut (
    .clk(clk), .rst(rst),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .aes_cmd(aes_cmd), .sha_cmd(sha_cmd),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .aes_rdata(aes_rdata), .sha_rdata(sha_rdata),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [1:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  ard;
    logic [7:0]  srd;
    logic [1:0]  req;   // {m1, m0}
    logic [15:0] a0;
    logic [15:0] a1;
    logic        en;
    logic        we;
    logic [15:0] maddr;
    logic [1:0]  acmd;
    logic [1:0]  scmd;
    logic [1:0]  ack;   // {m1, m0}
    logic        crv;
    logic [7:0]  crd;
    logic [1:0]  mrv;   // {m1, m0}
    logic [7:0]  mrd;
  } vec_t;

  vec_t tv [23];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    cpu_cmd = 2'd0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    aes_rdata = 8'h0; sha_rdata = 8'h0;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 16'h0; m0_wdata = 8'hD0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 16'h0; m1_wdata = 8'hD1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_outs"}, 0,
        {cpu_rdata, cpu_rvalid, aes_cmd, sha_cmd, m0_ack, m0_rvalid, m0_rdata,
         m1_ack, m1_rvalid, mem_en, mem_we, mem_wdata}, 32'h0);
    chk({nm, "_mem_addr"}, 0, {16'h0, mem_addr}, 32'h0);
    chk({nm, "_m1_rdata"}, 0, {24'h0, m1_rdata}, 32'h0);
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    sram[16'h0010] = 8'hA5; sram[16'h0100] = 8'hEE;
    sram[16'h0200] = 8'hB0; sram[16'h0201] = 8'hB1; sram[16'h0202] = 8'hB2;
    sram[16'h0300] = 8'hC0; sram[16'h0301] = 8'hC1;

    //       cmd   addr      wd     ard    srd    req    a0        a1         en   we   maddr     acmd  scmd  ack    crv  crd    mrv    mrd
    tv[0]  = '{2'd1, 16'h0010, 8'h00, 8'h00, 8'h00, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0010, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b00, 8'h00};
    tv[1]  = '{2'd2, 16'hFE05, 8'h3C, 8'h00, 8'h00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd2, 2'd0, 2'b00, 1'b1, 8'hA5, 2'b00, 8'h00};
    tv[2]  = '{2'd1, 16'hFE85, 8'h00, 8'h00, 8'h77, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd1, 2'b00, 1'b0, 8'h00, 2'b00, 8'h00};
    tv[3]  = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 2'b00, 1'b1, 8'h77, 2'b00, 8'h00};
    tv[4]  = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b11, 16'h0200, 16'h0300, 1'b1, 1'b0, 16'h0200, 2'd0, 2'd0, 2'b01, 1'b0, 8'h00, 2'b00, 8'h00};
    tv[5]  = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b11, 16'h0201, 16'h0300, 1'b1, 1'b0, 16'h0300, 2'd0, 2'd0, 2'b10, 1'b0, 8'h00, 2'b01, 8'hB0};
    tv[6]  = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b11, 16'h0201, 16'h0301, 1'b1, 1'b0, 16'h0201, 2'd0, 2'd0, 2'b01, 1'b0, 8'h00, 2'b10, 8'hC0};
    tv[7]  = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b11, 16'h0202, 16'h0301, 1'b1, 1'b0, 16'h0301, 2'd0, 2'd0, 2'b10, 1'b0, 8'h00, 2'b01, 8'hB1};
    tv[8]  = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b10, 8'hC1};
    tv[9]  = '{2'd2, 16'h0100, 8'h11, 8'h00, 8'h00, 2'b01, 16'h0100, 16'h0000, 1'b1, 1'b1, 16'h0100, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b00, 8'h00};
    tv[10] = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b01, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0100, 2'd0, 2'd0, 2'b01, 1'b0, 8'h00, 2'b00, 8'h00};
    tv[11] = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b01, 8'h11};
    for (int i = 12; i < 20; i++) begin
      tv[i] = '{2'd1, 16'h0010, 8'h00, 8'h00, 8'h00, 2'b11, 16'h0200, 16'h0300, 1'b1, 1'b0, 16'h0010, 2'd0, 2'd0, 2'b00,
                (i > 12), (i > 12) ? 8'hA5 : 8'h00, 2'b00, 8'h00};
    end
    tv[20] = '{2'd1, 16'hFE05, 8'h00, 8'h5A, 8'h00, 2'b11, 16'h0200, 16'h0300, 1'b1, 1'b0, 16'h0300, 2'd1, 2'd0, 2'b10, 1'b1, 8'hA5, 2'b00, 8'h00};
    tv[21] = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 2'b00, 1'b1, 8'h5A, 2'b10, 8'hC0};
    tv[22] = '{2'd0, 16'h0000, 8'h00, 8'h00, 8'h00, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b00, 8'h00};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("in_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      cpu_cmd = tv[i].cmd; cpu_addr = tv[i].addr; cpu_wdata = tv[i].wdata;
      aes_rdata = tv[i].ard; sha_rdata = tv[i].srd;
      m0_req = tv[i].req[0]; m0_addr = tv[i].a0;
      m1_req = tv[i].req[1]; m1_addr = tv[i].a1;
      @(negedge clk);
      chk("mem_en",     i, {31'h0, mem_en},      {31'h0, tv[i].en});
      chk("mem_we",     i, {31'h0, mem_we},      {31'h0, tv[i].we});
      chk("mem_addr",   i, {16'h0, mem_addr},    {16'h0, tv[i].maddr});
      chk("aes_cmd",    i, {30'h0, aes_cmd},     {30'h0, tv[i].acmd});
      chk("sha_cmd",    i, {30'h0, sha_cmd},     {30'h0, tv[i].scmd});
      chk("ack",        i, {30'h0, m1_ack, m0_ack}, {30'h0, tv[i].ack});
      chk("cpu_rvalid", i, {31'h0, cpu_rvalid},  {31'h0, tv[i].crv});
      chk("cpu_rdata",  i, {24'h0, cpu_rdata},   {24'h0, tv[i].crd});
      chk("rvalid",     i, {30'h0, m1_rvalid, m0_rvalid}, {30'h0, tv[i].mrv});
      chk("m0_rdata",   i, {24'h0, m0_rdata},    {24'h0, tv[i].mrv[0] ? tv[i].mrd : 8'h00});
      chk("m1_rdata",   i, {24'h0, m1_rdata},    {24'h0, tv[i].mrv[1] ? tv[i].mrd : 8'h00});
      chk("mmio",       i, {8'h0, mmio_addr, mmio_wdata}, {8'h0, tv[i].addr, tv[i].wdata});
    end

    // Reset lands while an m1 read is in flight.
    @(posedge clk); #1;
    m1_req = 1'b1; m1_addr = 16'h0300;
    @(negedge clk);
    chk("mid_rst_ack", 0, {31'h0, m1_ack}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", 0, {30'h0, m1_rvalid, cpu_rvalid}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", i, {29'h0, m1_rvalid, m0_rvalid, cpu_rvalid}, 32'h0);
    end

    // Arbiter pointer is back to its reset value: m0 wins contention.
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 16'h0200; m1_req = 1'b1; m1_addr = 16'h0300;
    @(negedge clk);
    chk("rst_rr_ack", 0, {30'h0, m1_ack, m0_ack}, 32'h1);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("rst_rr_rdata", 0, {23'h0, m0_rvalid, m0_rdata}, {23'h0, 1'b1, 8'hB0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
